fft_frame_tx: RTL and testbench
===============================

# fft_frame_tx

Frame transmitter that drives the sample input of `fft_core`. It accepts separate real/imaginary samples from an upstream producer and packs each pair into one 50-bit word. Complete 8-sample frames are held in a ping-pong buffer and streamed to the FFT over a valid/ready handshake, in natural or bit-reversed order. Upstream writing can continue while the FFT back-pressures.

## Interface
Parameters:
- `HALF_WIDTH`, default 25: width of each real/imag component, two's complement.
- `DATA_WIDTH`, default 50: packed word width; must equal 2*`HALF_WIDTH`.
- `FRAME_LEN`, default 8: samples per frame; must be a power of two.
- `BIT_REVERSE`, default 0: output order. 0 = natural index order; 1 = bit-reversed index order.

Ports:
- `clk_i` input 1: single clock; all logic on its rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `re_i` input `HALF_WIDTH`: real part of the input sample.
- `im_i` input `HALF_WIDTH`: imaginary part of the input sample.
- `wr_valid_i` input 1: the input sample is valid.
- `wr_ready_o` output 1: the block can accept a sample this cycle.
- `signal_o` output `DATA_WIDTH`: packed sample `{re, im}`; real part in [49:25], imag in [24:0].
- `valid_o` output 1: `signal_o` holds a valid sample.
- `ready_i` input 1: the FFT accepts `signal_o` this cycle.
- `last_o` output 1: the current output word is the final sample of its frame.

## Operation
- Storage is two banks of `FRAME_LEN` x `DATA_WIDTH` registers. Each bank has a `full` flag. The block keeps a write-bank pointer, a read-bank pointer, a write count and a read count, each `log2(FRAME_LEN)` bits.
- Write side:
  - Write handshake = `wr_valid_i && wr_ready_o`. On a handshake, `{re_i, im_i}` is stored at `bank[wr_bank][wr_cnt]` and `wr_cnt` increments.
  - When `wr_cnt` wraps from `FRAME_LEN-1` to 0, that bank's `full` is set and `wr_bank` toggles.
  - `wr_ready_o = !full[wr_bank]`.
- Read side:
  - `valid_o = full[rd_bank]`.
  - `signal_o = bank[rd_bank][idx]`, where `idx = rd_cnt` if `BIT_REVERSE` = 0, else `bitrev(rd_cnt)`. For 8 samples the bit-reversed order is 0,4,2,6,1,5,3,7.
  - `signal_o` is forced to 0 while `valid_o` = 0.
  - Read handshake = `valid_o && ready_i`; it increments `rd_cnt`.
  - When `rd_cnt` wraps, `full[rd_bank]` is cleared and `rd_bank` toggles.
  - `last_o = valid_o && (rd_cnt == FRAME_LEN-1)`.
- Packing is a plain concatenation: no rounding, sign extension or scaling.
- Back-pressure: while `valid_o && !ready_i`, `signal_o`, `last_o` and `rd_cnt` must stay stable.
- Simultaneous events:
  - A write that fills one bank and a read that drains the other bank on the same edge are both applied.
  - A write and a read can never target the same bank, because the `full` flag separates them.
- Reset, at any time: all `full` flags, pointers and counts go to 0. Any partial or queued frame is discarded. Sample registers need not be reset, since the `full` flags and `signal_o` gating hide them.

## Timing
- Reset values: `valid_o`=0, `last_o`=0, `signal_o`=0, `wr_ready_o`=1.
- Latency: the 8th write handshake at edge N makes `valid_o`=1 with sample index 0 during the cycle after edge N.
- Throughput: 1 sample/cycle on each side, sustained indefinitely when `ready_i` is held high.
- Buffering: up to 2 complete frames, plus 0 partial. `wr_ready_o` falls in the cycle after the 16th unread write.
- `wr_ready_o` rises again in the cycle after the read handshake that drains a bank.
- Outputs depend only on registered state; there is no combinational path from `ready_i` or `wr_valid_i` to any output.

## Test plan
1. Natural order: reset, then write k=0..7 with `re_i`=k and `im_i`=-k, with `ready_i`=1.
   - `valid_o` rises one cycle after the 8th write and stays high for 8 consecutive cycles.
   - `signal_o` = {k, -k} for k=0..7.
   - Sample 0 with re=im=1 must read as 50'h0000002000001.
   - `last_o` is high only on k=7.
2. Bit-reversed order: same stimulus with `BIT_REVERSE`=1 → emitted k order is 0,4,2,6,1,5,3,7, and `last_o` is high on k=7.
3. Back-pressure: `ready_i` toggles pseudo-randomly during a frame → exactly 8 handshakes, each value once, in order. `signal_o` is unchanged across every cycle with `ready_i`=0.
4. Full buffer:
   - Hold `ready_i`=0 and offer 24 writes → 16 accepted, and `wr_ready_o`=0 from the cycle after the 16th.
   - Then set `ready_i`=1 → frames 1 and 2 are emitted back-to-back in order.
   - `wr_ready_o` returns to 1 in the cycle after frame 1's 8th read.
5. Concurrent edge: while frame A streams out, time the 8th write of frame B onto the same edge as frame A's final read → `valid_o` stays high with no gap, and frame B's index 0 follows A's index 7 directly.
6. Reset mid-operation: assert `rst_i` after 5 writes of a frame and 3 reads of an earlier frame.
   - Immediately `valid_o`=0, `last_o`=0 and `wr_ready_o`=1, without waiting for a clock edge.
   - Eight subsequent writes form a fresh frame starting at index 0.

Source files
------------

// File: rtl/fft_frame_tx.sv
// fft_frame_tx: packs real/imag sample pairs into 50-bit words, collects
// them into frames held in a ping-pong buffer, and streams each complete
// frame to the FFT in natural or bit-reversed order over valid/ready.
module fft_frame_tx #(
  parameter int HALF_WIDTH  = 25,
  parameter int DATA_WIDTH  = 50,
  parameter int FRAME_LEN   = 8,
  parameter int BIT_REVERSE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [HALF_WIDTH-1:0] re_i,
  input  logic [HALF_WIDTH-1:0] im_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] signal_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [2][FRAME_LEN];
  logic [1:0]            full;
  logic [1:0]            full_next;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         rd_idx;
  logic                  wr_fire;
  logic                  rd_fire;

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < CW; i++) begin
      r[i] = v[CW-1-i];
    end
    return r;
  endfunction

  // A bank accepts writes only while it is not holding an unread frame, and
  // the read side is valid only while its bank holds a complete frame, so the
  // full flags alone keep writer and reader on different banks.
  assign wr_ready_o = !full[wr_bank];
  assign valid_o    = full[rd_bank];
  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign rd_fire    = valid_o && ready_i;
  assign rd_idx     = (BIT_REVERSE != 0) ? bitrev(rd_cnt) : rd_cnt;
  assign signal_o   = valid_o ? mem[rd_bank][rd_idx] : '0;
  assign last_o     = valid_o && (rd_cnt == LAST_IDX);

  // Sample storage; not reset because the full flags and output gating hide stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[wr_bank][wr_cnt] <= DATA_WIDTH'({re_i, im_i});
    end
  end

  // Full-flag update: a write can fill one bank while a read drains the other on the same edge.
  always_comb begin
    full_next = full;
    if (wr_fire && (wr_cnt == LAST_IDX)) begin
      full_next[wr_bank] = 1'b1;
    end
    if (rd_fire && (rd_cnt == LAST_IDX)) begin
      full_next[rd_bank] = 1'b0;
    end
  end

  // Bank pointers, counters and full flags; reset discards every partial or queued frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      full <= full_next;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + CW'(1);
        if (wr_cnt == LAST_IDX) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + CW'(1);
        if (rd_cnt == LAST_IDX) begin
          rd_bank <= ~rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_tx.sv
// tb_fft_frame_tx: drives a natural-order and a bit-reversed instance with
// identical stimulus and compares both against a queue-based frame model.
module tb_fft_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] re;
  logic [24:0] im;
  logic        wr_valid;
  logic        ready;

  logic        wr_ready_n, valid_n, last_n;
  logic [49:0] signal_n;
  logic        wr_ready_b, valid_b, last_b;
  logic [49:0] signal_b;

  int checks = 0;
  int errors = 0;

  // Model state: complete unread frames (8 words each, oldest first),
  // the partial frame being written, and the read position in the head frame.
  logic [49:0] done_q[$];
  logic [49:0] part_q[$];
  int          rd_pos = 0;

  always #5 clk = ~clk;

  fft_frame_tx #(.BIT_REVERSE(0)) dut_nat (
    .clk_i(clk), .rst_i(rst), .re_i(re), .im_i(im),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_n),
    .signal_o(signal_n), .valid_o(valid_n), .ready_i(ready), .last_o(last_n)
  );

  fft_frame_tx #(.BIT_REVERSE(1)) dut_rev (
    .clk_i(clk), .rst_i(rst), .re_i(re), .im_i(im),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_b),
    .signal_o(signal_b), .valid_o(valid_b), .ready_i(ready), .last_o(last_b)
  );

  function automatic int rev_index(input int p);
    case (p)
      0: return 0;  1: return 4;  2: return 2;  3: return 6;
      4: return 1;  5: return 5;  6: return 3;  default: return 7;
    endcase
  endfunction

  function automatic bit m_valid();
    return done_q.size() >= 8;
  endfunction

  function automatic bit m_wr_ready();
    return done_q.size() < 16;
  endfunction

  task automatic check_output(input string name, input logic [49:0] act, input logic [49:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each clock edge; reset empties every frame.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      done_q.delete();
      part_q.delete();
      rd_pos = 0;
    end else begin
      bit do_rd;
      bit do_wr;
      do_rd = m_valid() && ready;
      do_wr = wr_valid && m_wr_ready();
      if (do_rd) begin
        rd_pos++;
        if (rd_pos == 8) begin
          for (int i = 0; i < 8; i++) void'(done_q.pop_front());
          rd_pos = 0;
        end
      end
      if (do_wr) begin
        part_q.push_back({re, im});
        if (part_q.size() == 8) begin
          for (int i = 0; i < 8; i++) done_q.push_back(part_q[i]);
          part_q.delete();
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  initial forever begin
    logic        e_valid, e_wr, e_last;
    logic [49:0] e_nat, e_rev;
    @(negedge clk);
    e_valid = m_valid();
    e_wr    = m_wr_ready();
    e_last  = e_valid && (rd_pos == 7);
    e_nat   = e_valid ? done_q[rd_pos] : 50'd0;
    e_rev   = e_valid ? done_q[rev_index(rd_pos)] : 50'd0;
    check_output("valid_nat", {49'd0, valid_n}, {49'd0, e_valid});
    check_output("valid_rev", {49'd0, valid_b}, {49'd0, e_valid});
    check_output("wr_ready_nat", {49'd0, wr_ready_n}, {49'd0, e_wr});
    check_output("wr_ready_rev", {49'd0, wr_ready_b}, {49'd0, e_wr});
    check_output("last_nat", {49'd0, last_n}, {49'd0, e_last});
    check_output("last_rev", {49'd0, last_b}, {49'd0, e_last});
    check_output("signal_nat", signal_n, e_nat);
    check_output("signal_rev", signal_b, e_rev);
  end

  task automatic apply_stimulus(input bit v, input logic [24:0] r, input logic [24:0] i, input bit rdy);
    @(negedge clk);
    wr_valid = v;
    re       = r;
    im       = i;
    ready    = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    wr_valid = 1'b0;
    ready    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    ready    = 1'b0;
    re       = '0;
    im       = '0;

    // Reset values
    do_reset();
    check_output("reset_valid", {49'd0, valid_n}, 50'd0);
    check_output("reset_wr_ready", {49'd0, wr_ready_n}, 50'd1);
    check_output("reset_signal", signal_n, 50'd0);

    // Directed frame: sample 0 is (1,1), the rest (k,-k), ready held high
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b1, (k == 0) ? 25'd1 : 25'(k), (k == 0) ? 25'd1 : 25'(-k), 1'b1);
      if (k == 7) check_output("latency_pre_valid", {49'd0, valid_n}, 50'd0);
    end
    apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("t0_valid", {49'd0, valid_n}, 50'd1);
    check_output("t0_nat", signal_n, 50'h0000002000001);
    check_output("t0_rev", signal_b, 50'h0000002000001);
    apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("t1_nat", signal_n, 50'h0000003FFFFFF);
    check_output("t1_rev", signal_b, 50'h0000009FFFFFC);
    apply_stimulus(1'b0, '0, '0, 1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("t3_nat", signal_n, 50'h0000007FFFFFD);
    for (int t = 4; t < 8; t++) apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("t7_last_nat", {49'd0, last_n}, 50'd1);
    check_output("t7_last_rev", {49'd0, last_b}, 50'd1);
    check_output("t7_rev", signal_b, 50'h000000FFFFFF9);
    for (int t = 0; t < 4; t++) apply_stimulus(1'b0, '0, '0, 1'b1);

    // Full buffer: 24 offered writes with ready low, then drain
    do_reset();
    for (int n = 0; n < 24; n++) begin
      apply_stimulus(1'b1, 25'(n + 200), 25'(n), 1'b0);
      if (n == 15) check_output("full_wr_ready_15", {49'd0, wr_ready_n}, 50'd1);
      if (n == 16) check_output("full_wr_ready_16", {49'd0, wr_ready_n}, 50'd0);
    end
    for (int d = 0; d < 20; d++) begin
      apply_stimulus(1'b0, '0, '0, 1'b1);
      if (d == 7) check_output("drain_wr_ready_7", {49'd0, wr_ready_n}, 50'd0);
      if (d == 8) check_output("drain_wr_ready_8", {49'd0, wr_ready_n}, 50'd1);
    end

    // Concurrent edge: frame B's last write meets frame A's last read
    do_reset();
    for (int n = 0; n < 16; n++) apply_stimulus(1'b1, 25'(n), 25'(n + 50), 1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("handover_valid", {49'd0, valid_n}, 50'd1);
    check_output("handover_nat", signal_n, 50'h000001000003A);
    check_output("handover_rev", signal_b, 50'h000001000003A);
    for (int t = 0; t < 10; t++) apply_stimulus(1'b0, '0, '0, 1'b1);

    // Reset mid-operation: 3 reads of frame A done, 5 writes of frame B done
    do_reset();
    for (int n = 0; n < 8; n++) apply_stimulus(1'b1, 25'(n + 300), 25'(n), 1'b0);
    for (int j = 0; j < 5; j++) apply_stimulus(1'b1, 25'(j + 400), 25'(j), j >= 2);
    @(posedge clk);
    #2;
    check_output("pre_rst_valid", {49'd0, valid_n}, 50'd1);
    rst = 1'b1;
    #1;
    check_output("async_rst_valid_nat", {49'd0, valid_n}, 50'd0);
    check_output("async_rst_last_nat", {49'd0, last_n}, 50'd0);
    check_output("async_rst_wr_ready_nat", {49'd0, wr_ready_n}, 50'd1);
    check_output("async_rst_valid_rev", {49'd0, valid_b}, 50'd0);
    check_output("async_rst_wr_ready_rev", {49'd0, wr_ready_b}, 50'd1);
    @(negedge clk);
    rst      = 1'b0;
    wr_valid = 1'b0;
    ready    = 1'b0;
    for (int k = 0; k < 8; k++) apply_stimulus(1'b1, 25'(k + 100), 25'(k), 1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("fresh_frame_idx0", signal_n, 50'h00000C8000000);
    for (int t = 0; t < 10; t++) apply_stimulus(1'b0, '0, '0, 1'b1);

    // Randomized traffic with varying back-pressure
    do_reset();
    for (int seg = 0; seg < 20; seg++) begin
      int bias;
      bias = $urandom_range(0, 3);
      for (int c = 0; c < 150; c++) begin
        apply_stimulus($urandom_range(0, 3) != 0, 25'($urandom), 25'($urandom),
                       $urandom_range(0, 3) >= bias);
      end
    end
    for (int t = 0; t < 30; t++) apply_stimulus(1'b0, '0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
